// File: rtl/cfg_chain_loader.sv
// Serial configuration-chain loader: shifts host bytes MSB-first into a scan chain,
// or rotates the chain in place and compares it against the host bytes.
module cfg_chain_loader #(
  parameter int LEN_WIDTH = 12
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 START,
  input  logic                 MODE,
  input  logic [LEN_WIDTH-1:0] CHAIN_LEN,
  input  logic                 ABORT,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [7:0]           IN_DATA,
  output logic                 CFG_WE,
  output logic                 CFG_D,
  input  logic                 CFG_Q,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [7:0]           ERR_CNT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2,
    FIN       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [7:0]           sr_q, sr_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic                 err_q, err_d;
  logic [7:0]           ecnt_q, ecnt_d;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      sr_q    <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          mode_d  = MODE;
          rem_d   = CHAIN_LEN;
          err_d   = 1'b0;
          ecnt_d  = '0;
          state_d = (CHAIN_LEN == '0) ? FIN : WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (IN_VALID) begin
          sr_d    = IN_DATA;
          // A short final byte uses only its upper bits.
          bcnt_d  = (rem_q >= LEN_WIDTH'(8)) ? 4'd8 : rem_q[3:0];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d   = {sr_q[6:0], 1'b0};
        bcnt_d = bcnt_q - 4'd1;
        rem_d  = rem_q - LEN_WIDTH'(1);
        if (mode_q && (CFG_Q != sr_q[7])) begin
          err_d = 1'b1;
          if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        end
        if (bcnt_q == 4'd1) state_d = (rem_q == LEN_WIDTH'(1)) ? FIN : WAIT_BYTE;
        if (ABORT) state_d = IDLE;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Verify mode feeds the tail back to the head so the chain is restored.
  assign CFG_WE   = (state_q == SHIFT);
  assign CFG_D    = (state_q == SHIFT) ? (mode_q ? CFG_Q : sr_q[7]) : 1'b0;
  assign IN_READY = (state_q == WAIT_BYTE) && !ABORT;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == FIN);
  assign ERR      = err_q;
  assign ERR_CNT  = ecnt_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader driving a 12-bit external chain model.
module tb_cfg_chain_loader;

  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        START = 1'b0;
  logic        MODE = 1'b0;
  logic [11:0] CHAIN_LEN = '0;
  logic        ABORT = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  IN_DATA = '0;
  logic        CFG_WE;
  logic        CFG_D;
  logic        CFG_Q;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [7:0]  ERR_CNT;

  cfg_chain_loader #(.LEN_WIDTH(12)) dut (
    .CLK(CLK), .RSTB(RSTB), .START(START), .MODE(MODE), .CHAIN_LEN(CHAIN_LEN),
    .ABORT(ABORT), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .CFG_WE(CFG_WE), .CFG_D(CFG_D), .CFG_Q(CFG_Q), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // External chain: first bit shifted in ends up at the tail after 12 shifts.
  logic [11:0] chain = '0;
  always @(posedge CLK) if (CFG_WE) chain <= {chain[10:0], CFG_D};
  assign CFG_Q = chain[11];

  int total = 0;
  int bad   = 0;
  int we_cycles = 0;
  int done_cnt  = 0;
  logic       bit_q[$];
  logic [8:0] done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTB) begin
      if (CFG_WE) begin
        we_cycles++;
        if (bit_q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
        else chk("cfg_d_bit", 32'(CFG_D), 32'(bit_q.pop_front()));
      end
      if (DONE) begin
        done_cnt++;
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_err_cnt", 32'({ERR, ERR_CNT}), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(b[7-i]);
  endtask

  task automatic do_start(input logic m, input logic [11:0] len);
    START = 1'b1; MODE = m; CHAIN_LEN = len;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (IN_READY) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    IN_DATA = b; IN_VALID = 1'b1;
    wait_ready(ok);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!BUSY) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, dn0;
    bit ok;
    #1;
    chk("reset_outputs", 32'({IN_READY, CFG_WE, CFG_D, BUSY, DONE, ERR, ERR_CNT}), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RSTB = 1'b1;
    @(posedge CLK); #1;

    // Load 12 bits: A5 then upper nibble of C0.
    we0 = we_cycles; dn0 = done_cnt;
    push_bits(8'hA5, 8); push_bits(8'hC0, 4); done_q.push_back(9'h000);
    do_start(1'b0, 12'd12);
    send_byte(8'hA5); send_byte(8'hC0);
    wait_idle();
    chk("load_chain", 32'(chain), 32'hA5C);
    chk("load_we_cycles", 32'(we_cycles - we0), 32'd12);
    chk("load_done_pulses", 32'(done_cnt - dn0), 32'd1);

    // Verify pass: the chain rotates so CFG_D repeats the stored pattern.
    push_bits(8'hA5, 8); push_bits(8'hC0, 4); done_q.push_back(9'h000);
    do_start(1'b1, 12'd12);
    send_byte(8'hA5); send_byte(8'hC0);
    wait_idle();
    chk("verify_chain_kept", 32'(chain), 32'hA5C);
    chk("verify_pass_err", 32'({ERR, ERR_CNT}), 32'h000);

    // Verify fail: A4 differs from A5 in one bit.
    push_bits(8'hA5, 8); push_bits(8'hC0, 4); done_q.push_back(9'h101);
    do_start(1'b1, 12'd12);
    send_byte(8'hA4); send_byte(8'hC0);
    wait_idle();
    repeat (3) @(posedge CLK); #1;
    chk("verify_fail_held", 32'({ERR, ERR_CNT}), 32'h101);
    chk("verify_fail_chain", 32'(chain), 32'hA5C);

    // Zero length: DONE on the cycle after START, no shifting, ERR cleared.
    we0 = we_cycles;
    done_q.push_back(9'h000);
    do_start(1'b0, 12'd0);
    chk("len0_done", 32'(DONE), 32'd1);
    wait_idle();
    chk("len0_no_we", 32'(we_cycles - we0), 32'd0);

    // START while busy is ignored; a 10-cycle stall keeps CFG_WE low.
    dn0 = done_cnt;
    push_bits(8'hA5, 8); push_bits(8'hC0, 4); done_q.push_back(9'h000);
    do_start(1'b0, 12'd12);
    send_byte(8'hA5);
    START = 1'b1; MODE = 1'b1; CHAIN_LEN = 12'd0;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_ready(ok);
    for (int i = 0; i < 10; i++) begin
      chk("stall_we_low", 32'(CFG_WE), 32'd0);
      @(posedge CLK); #1;
    end
    send_byte(8'hC0);
    wait_idle();
    chk("stall_chain", 32'(chain), 32'hA5C);
    chk("stall_done_once", 32'(done_cnt - dn0), 32'd1);

    // ABORT during the third shift cycle: exactly 3 bits shift, no DONE.
    dn0 = done_cnt;
    push_bits(8'hFF, 3);
    do_start(1'b0, 12'd12);
    send_byte(8'hFF);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    chk("abort_idle", 32'({BUSY, CFG_WE}), 32'd0);
    repeat (3) @(posedge CLK); #1;
    chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    chk("abort_chain", 32'(chain), 32'h2E7);

    // ABORT with IN_VALID: byte refused.
    we0 = we_cycles;
    do_start(1'b0, 12'd8);
    IN_DATA = 8'h3C; IN_VALID = 1'b1; ABORT = 1'b1;
    #1;
    chk("abort_ready_low", 32'(IN_READY), 32'd0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; ABORT = 1'b0;
    chk("abort_valid_idle", 32'(BUSY), 32'd0);
    repeat (3) @(posedge CLK); #1;
    chk("abort_byte_not_used", 32'(we_cycles - we0), 32'd0);

    // Reset during SHIFT, then a clean 8-bit load.
    do_start(1'b0, 12'd12);
    send_byte(8'h81);
    RSTB = 1'b0;
    #1;
    chk("midreset_outputs", 32'({IN_READY, CFG_WE, CFG_D, BUSY, DONE, ERR, ERR_CNT}), 32'd0);
    @(posedge CLK); #1;
    RSTB = 1'b1;
    @(posedge CLK); #1;
    dn0 = done_cnt; we0 = we_cycles;
    push_bits(8'hFF, 8); done_q.push_back(9'h000);
    do_start(1'b0, 12'd8);
    send_byte(8'hFF);
    wait_idle();
    chk("post_reset_we", 32'(we_cycles - we0), 32'd8);
    chk("post_reset_done", 32'(done_cnt - dn0), 32'd1);

    chk("bits_drained", 32'(bit_q.size()), 32'd0);
    chk("dones_drained", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
